seq_pattern_tx: RTL

- Serial bit-pattern transmitter. It is the driving end of the single-bit sequence-detector interface: it produces the x_in stream that a detector FSM consumes.
- Loads a parallel pattern on a start request and shifts it out MSB-first on x_out. Each bit is held for a programmable number of clocks.
- Reports busy, a per-bit strobe and a one-cycle done pulse.
- Used as a stimulus and source block in front of the detector in lab-level designs.

---
 rtl/seq_pattern_tx_if.sv | 23 ++
 rtl/seq_pattern_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx_if.sv
// Parallel-load / serial-out handshake bundle between a pattern source and seq_pattern_tx.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern_in;
    logic [LEN_W-1:0] len_in;
    logic             x_out;
    logic             busy;
    logic             bit_strobe;
    logic             done;

    modport master (
        output start, pattern_in, len_in,
        input  x_out, busy, bit_strobe, done
    );

    modport slave (
        input  start, pattern_in, len_in,
        output x_out, busy, bit_strobe, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts pattern_in[L-1:0] out MSB-first, DIV clocks per bit.
// Define SEQ_TX_PARITY_EN to append one even-parity bit after the data bits.
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int DIV   = 1
) (
    input logic             clk,
    input logic             reset,
    seq_pattern_tx_if.slave bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [LEN_W-1:0] bit_cnt, bit_cnt_n;
    logic [DIV_W-1:0] div_cnt, div_cnt_n;
    logic             x_q, x_n;
    logic             busy_q, busy_n;
    logic             strobe_q, strobe_n;
    logic             done_q, done_n;
    logic [LEN_W-1:0] len_eff;
    logic [WIDTH-1:0] aligned;
`ifdef SEQ_TX_PARITY_EN
    logic             par, par_n;
    logic [WIDTH-1:0] mask;
`endif

    // Clamp the length and left-justify the selected bits so the MSB always leaves from the top.
    always_comb begin
        len_eff = (bus.len_in > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len_in;
        aligned = bus.pattern_in << (LEN_W'(WIDTH) - len_eff);
`ifdef SEQ_TX_PARITY_EN
        mask    = (WIDTH'(1) << len_eff) - WIDTH'(1);
`endif
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        x_n       = 1'b0;
        busy_n    = 1'b0;
        strobe_n  = 1'b0;
        done_n    = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_n     = par;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start && (len_eff != '0)) begin
                    state_n   = SHIFT;
                    shreg_n   = aligned;
                    x_n       = aligned[WIDTH-1];
                    busy_n    = 1'b1;
                    strobe_n  = 1'b1;
                    div_cnt_n = '0;
`ifdef SEQ_TX_PARITY_EN
                    // bit_cnt counts bits still to follow, parity bit included
                    bit_cnt_n = len_eff;
                    par_n     = ^(bus.pattern_in & mask);
`else
                    bit_cnt_n = len_eff - LEN_W'(1);
`endif
                end
            end
            SHIFT: begin
                busy_n = 1'b1;
                x_n    = x_q;
                if (div_cnt == DIV_W'(DIV - 1)) begin
                    div_cnt_n = '0;
                    if (bit_cnt == '0) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        x_n     = 1'b0;
                        done_n  = 1'b1;
                        shreg_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt - LEN_W'(1);
                        shreg_n   = shreg << 1;
                        x_n       = shreg_n[WIDTH-1];
                        strobe_n  = 1'b1;
`ifdef SEQ_TX_PARITY_EN
                        if (bit_cnt == LEN_W'(1)) begin
                            x_n = par;
                        end
`endif
                    end
                end else begin
                    div_cnt_n = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                div_cnt_n = '0;
`ifdef SEQ_TX_PARITY_EN
                par_n     = 1'b0;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            div_cnt  <= div_cnt_n;
            x_q      <= x_n;
            busy_q   <= busy_n;
            strobe_q <= strobe_n;
            done_q   <= done_n;
`ifdef SEQ_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    assign bus.x_out      = x_q;
    assign bus.busy       = busy_q;
    assign bus.bit_strobe = strobe_q;
    assign bus.done       = done_q;
endmodule
